// File: rtl/shared_counters_pkg.sv
// Shared types and sizing for the counter readback path.
// Holds the array geometry, the readback record layout and the assembler FSM states.
package shared_counters_pkg;

  localparam int N           = 10;
  localparam int G           = 4;
  localparam int W           = 64;
  localparam int TIMEOUT_CYC = 16;

  localparam int CHUNK_CNT_W = $clog2(N) + 1;
  localparam int ID_W        = $clog2(N);
  localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic [W-1:0]           data;
    logic [ID_W-1:0]        id;
    logic [CHUNK_CNT_W-1:0] len;
    logic                   trunc;
    logic                   timeout;
  } readback_rec_t;

  typedef enum logic {RB_IDLE, RB_COLLECT} rb_state_t;

endpackage

// File: rtl/readback_fifo.sv
// Small first-word fall-through FIFO for assembled readback records.
// A pop and a push in the same cycle are allowed even when full: the pop frees the slot first.
module readback_fifo
  import shared_counters_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  readback_rec_t push_data,
  input  logic          pop,
  output readback_rec_t head,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  readback_rec_t    mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pop-before-push keeps a full FIFO writable when draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_readback_assembler.sv
// Reassembles the serial LSB-first chunk stream from the shared-counter array into tagged records.
// Upstream cannot be stalled, so records that find the FIFO full are dropped and counted.
// Optional feature: define READBACK_TIMEOUT_EN to close idle frames after TIMEOUT_CYC gap cycles.
module counter_readback_assembler
  import shared_counters_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_valid_in,
  input  logic [G-1:0]           rd_data_in,
  input  logic                   rd_last_in,
  input  logic [ID_W-1:0]        rd_id_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [ID_W-1:0]        out_id,
  output logic [CHUNK_CNT_W-1:0] out_len,
  output logic                   out_trunc,
  output logic                   out_timeout,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_drop
);

  rb_state_t              state;
  rb_state_t              next_state;
  logic [W-1:0]           acc;
  logic [CHUNK_CNT_W-1:0] cnt;
  logic [ID_W-1:0]        id_q;
  logic                   trunc_q;

  logic [31:0]            pos;
  logic                   chunk_trunc;
  logic                   chunk_close;
  logic                   timeout_close;
  logic                   close;
  logic                   drop;
  readback_rec_t          rec;
  readback_rec_t          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RB_IDLE;
    else     state <= next_state;
  end

  // Any accepted chunk opens or continues a frame; a close always returns to IDLE.
  always_comb begin
    next_state = state;
    if (close)            next_state = RB_IDLE;
    else if (rd_valid_in) next_state = RB_COLLECT;
  end

  // Merge the current chunk into the accumulator and decide whether this edge closes the frame.
  always_comb begin
    pos         = 32'(cnt) * G;
    chunk_trunc = rd_valid_in && (pos >= W);
    chunk_close = rd_valid_in && (rd_last_in || ((cnt + 1'b1) == CHUNK_CNT_W'(N)));
    close       = chunk_close || timeout_close;
    rec         = '0;
    rec.data    = rd_valid_in ? (acc | (W'(rd_data_in) << pos)) : acc;
    rec.id      = (state == RB_IDLE) ? rd_id_in : id_q;
    rec.len     = rd_valid_in ? (cnt + 1'b1) : cnt;
    rec.trunc   = trunc_q || chunk_trunc;
    rec.timeout = timeout_close && !chunk_close;
  end

  // Frame accumulator; cleared on every close so IDLE always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      id_q    <= '0;
      trunc_q <= 1'b0;
    end else if (close) begin
      acc     <= '0;
      cnt     <= '0;
      id_q    <= '0;
      trunc_q <= 1'b0;
    end else if (rd_valid_in) begin
      acc     <= rec.data;
      cnt     <= rec.len;
      id_q    <= rec.id;
      trunc_q <= rec.trunc;
    end
  end

`ifdef READBACK_TIMEOUT_EN
  logic [GAP_W-1:0] gap_cnt;

  assign timeout_close = (state == RB_COLLECT) && !rd_valid_in &&
                         (gap_cnt == GAP_W'(TIMEOUT_CYC - 1));

  // Idle-gap counter: runs only while a frame is open and no chunk arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              gap_cnt <= '0;
    else if (state != RB_COLLECT || rd_valid_in || close) gap_cnt <= '0;
    else                                                  gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign timeout_close = 1'b0;
`endif

  assign pop  = out_valid && out_ready;
  assign drop = close && fifo_full && !pop;

  readback_fifo #(.DEPTH(2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (close),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_data    = head.data;
  assign out_id      = head.id;
  assign out_len     = head.len;
  assign out_trunc   = head.trunc;
  assign out_timeout = head.timeout;

  // Saturating lost-record counter; a clear in the same cycle as a drop leaves one drop counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_cnt <= 8'd0;
    else if (clr_drop)                drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_counter_readback_assembler.sv
// Directed self-checking bench for counter_readback_assembler (N=10, G=4, W=64).
// Timeout checks follow READBACK_TIMEOUT_EN as defined for the build.
module tb_counter_readback_assembler;
  import shared_counters_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rd_valid_in;
  logic [G-1:0]           rd_data_in;
  logic                   rd_last_in;
  logic [ID_W-1:0]        rd_id_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_data;
  logic [ID_W-1:0]        out_id;
  logic [CHUNK_CNT_W-1:0] out_len;
  logic                   out_trunc;
  logic                   out_timeout;
  logic [7:0]             drop_cnt;
  logic                   clr_drop;

  int total = 0;
  int bad   = 0;

  counter_readback_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .rd_valid_in (rd_valid_in),
    .rd_data_in  (rd_data_in),
    .rd_last_in  (rd_last_in),
    .rd_id_in    (rd_id_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_len     (out_len),
    .out_trunc   (out_trunc),
    .out_timeout (out_timeout),
    .drop_cnt    (drop_cnt),
    .clr_drop    (clr_drop)
  );

  always #5 clk = ~clk;

  // Drive one cycle of the chunk stream, then settle 1 ns past the edge for checking.
  task automatic applyStimulus(input logic v, input logic [G-1:0] d, input logic l,
                               input logic [ID_W-1:0] id);
    rd_valid_in = v;
    rd_data_in  = d;
    rd_last_in  = l;
    rd_id_in    = id;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; rd_valid_in = 1'b0; rd_data_in = '0; rd_last_in = 1'b0;
    rd_id_in = '0; out_ready = 1'b0; clr_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid",   64'(out_valid),   64'h0);
    checkOutput("rst_data",    out_data,         64'h0);
    checkOutput("rst_id",      64'(out_id),      64'h0);
    checkOutput("rst_len",     64'(out_len),     64'h0);
    checkOutput("rst_trunc",   64'(out_trunc),   64'h0);
    checkOutput("rst_timeout", 64'(out_timeout), 64'h0);
    checkOutput("rst_drop",    64'(drop_cnt),    64'h0);
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] three-chunk frame");
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'hA, 1'b0, 4'd3);
    applyStimulus(1'b1, 4'h5, 1'b0, 4'd3);
    checkOutput("t1_not_yet", 64'(out_valid), 64'h0);
    applyStimulus(1'b1, 4'hC, 1'b1, 4'd3);
    checkOutput("t1_valid", 64'(out_valid), 64'h1);
    checkOutput("t1_data",  out_data,       64'hC5A);
    checkOutput("t1_id",    64'(out_id),    64'd3);
    checkOutput("t1_len",   64'(out_len),   64'd3);
    checkOutput("t1_trunc", 64'(out_trunc), 64'h0);
    idleCycles(1);
    checkOutput("t1_popped", 64'(out_valid), 64'h0);

    $display("[TB] ten chunks without last");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'(i), 1'b0, 4'd0);
    checkOutput("t2_open_at9", 64'(out_valid), 64'h0);
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd0);
    checkOutput("t2_valid", 64'(out_valid), 64'h1);
    checkOutput("t2_data",  out_data,       64'h9876543210);
    checkOutput("t2_len",   64'(out_len),   64'd10);
    checkOutput("t2_id",    64'(out_id),    64'd0);
    idleCycles(1);
    checkOutput("t2_popped", 64'(out_valid), 64'h0);

    $display("[TB] overflow with consumer stalled");
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h1, 1'b1, 4'd1);
    applyStimulus(1'b1, 4'h2, 1'b1, 4'd2);
    applyStimulus(1'b1, 4'h3, 1'b1, 4'd3);
    checkOutput("t3_drop",  64'(drop_cnt),  64'd1);
    checkOutput("t3_head",  out_data,       64'h1);
    idleCycles(2);
    checkOutput("t3_hold_valid", 64'(out_valid), 64'h1);
    checkOutput("t3_hold_data",  out_data,       64'h1);
    checkOutput("t3_hold_id",    64'(out_id),    64'd1);
    out_ready = 1'b1;
    idleCycles(1);
    checkOutput("t3_pop2", out_data, 64'h2);
    idleCycles(1);
    checkOutput("t3_empty", 64'(out_valid), 64'h0);

    $display("[TB] pop and close on a full FIFO");
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h1, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'h2, 1'b1, 4'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'h7, 1'b1, 4'd0);
    checkOutput("t4_drop",  64'(drop_cnt), 64'd1);
    checkOutput("t4_head2", out_data,      64'h2);
    idleCycles(1);
    checkOutput("t4_head7", out_data,      64'h7);
    idleCycles(1);
    checkOutput("t4_empty", 64'(out_valid), 64'h0);

    $display("[TB] drop counter clear");
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h1, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'h2, 1'b1, 4'd0);
    applyStimulus(1'b1, 4'h3, 1'b1, 4'd0);
    checkOutput("clr_pre", 64'(drop_cnt), 64'd2);
    clr_drop = 1'b1;
    applyStimulus(1'b1, 4'h4, 1'b1, 4'd0);
    checkOutput("clr_with_drop", 64'(drop_cnt), 64'd1);
    idleCycles(1);
    checkOutput("clr_alone", 64'(drop_cnt), 64'd0);
    clr_drop = 1'b0;
    out_ready = 1'b1;
    idleCycles(2);
    checkOutput("clr_drained", 64'(out_valid), 64'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 4'h6, 1'b0, 4'd2);
    applyStimulus(1'b1, 4'h7, 1'b0, 4'd2);
    rd_valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t5_after_rst", 64'(out_valid), 64'h0);
    applyStimulus(1'b1, 4'hF, 1'b1, 4'd5);
    checkOutput("t5_valid", 64'(out_valid), 64'h1);
    checkOutput("t5_data",  out_data,       64'hF);
    checkOutput("t5_len",   64'(out_len),   64'd1);
    checkOutput("t5_id",    64'(out_id),    64'd5);
    idleCycles(1);
    checkOutput("t5_single", 64'(out_valid), 64'h0);

    $display("[TB] idle gap in an open frame");
    applyStimulus(1'b1, 4'h4, 1'b0, 4'd1);
    applyStimulus(1'b1, 4'h8, 1'b0, 4'd1);
    idleCycles(15);
    checkOutput("t6_before_limit", 64'(out_valid), 64'h0);
    idleCycles(1);
`ifdef READBACK_TIMEOUT_EN
    checkOutput("t6_valid",   64'(out_valid),   64'h1);
    checkOutput("t6_data",    out_data,         64'h84);
    checkOutput("t6_timeout", 64'(out_timeout), 64'h1);
    checkOutput("t6_len",     64'(out_len),     64'd2);
    checkOutput("t6_id",      64'(out_id),      64'd1);
    idleCycles(1);
    checkOutput("t6_popped", 64'(out_valid), 64'h0);
`else
    checkOutput("t6_no_record", 64'(out_valid), 64'h0);
    idleCycles(10);
    checkOutput("t6_still_none", 64'(out_valid), 64'h0);
    applyStimulus(1'b1, 4'h1, 1'b1, 4'd7);
    checkOutput("t6_late_data",    out_data,         64'h184);
    checkOutput("t6_late_len",     64'(out_len),     64'd3);
    checkOutput("t6_late_id",      64'(out_id),      64'd1);
    checkOutput("t6_late_timeout", 64'(out_timeout), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
